sensor_conditioner: RTL
=======================

Name: sensor_conditioner

Overview:
Front-end stage directly upstream of the four-way traffic light controller. It conditions eight raw asynchronous loop-detector inputs (four first-car loops, four fifth-car loops) into the clean `sensor_1th` / `sensor_5th` vectors that the controller samples. It provides synchronisation, debounce, latched call requests cleared by the controller's green feedback, and sticky detector-fault detection. Lane bit order everywhere: 0 north, 1 east, 2 south, 3 west.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronised cycles an input must disagree with its debounced value before the debounced value flips (min 1, max 255)
FAULT_CYCLES, 64, consecutive cycles of debounced 5th-loop high with debounced 1th-loop low before the lane is flagged faulty (min 1, max 65535)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, synchronous, active-low
loop_1th_raw  input  4  raw first-car loop detectors, asynchronous to clk
loop_5th_raw  input  4  raw fifth-car loop detectors, asynchronous to clk
Light_north  input  2  controller feedback, encoding 10 green / 01 yellow / 00 red
Light_east  input  2  as above
Light_south  input  2  as above
Light_west  input  2  as above
sensor_1th  output  4  latched call request per lane, registered
sensor_5th  output  4  qualified long-queue indication per lane, registered
sensor_fault  output  4  sticky per-lane detector fault, registered

Behaviour:
- Reset (rst==0 at a clk edge): sync flops, debounced values, counters, call latches, fault flags and all outputs become 0. Reset asserted mid-operation clears everything at that edge; no partial state survives.
- Synchroniser: 2-flop per raw bit; only the second flop's output (s) is used downstream.
- Debounce, per bit (8 instances): deb register, count register.
  - s==deb: count<=0.
  - s!=deb and count==DEBOUNCE_CYCLES-1: deb<=s, count<=0.
  - Otherwise: count<=count+1.
  - Glitches shorter than DEBOUNCE_CYCLES synchronised cycles never reach deb.
- Call latch, per lane i:
  - Set when deb1[i]==1.
  - Cleared when deb1[i]==0 and the lane's light==10 (green).
  - Otherwise holds.
  - Set and clear are mutually exclusive by construction.
  - A call is therefore kept through yellow/red until the lane has been served green with the loop empty.
  - Yellow (01) never clears.
- Fault, per lane: fcount counts cycles with deb5[i]==1 and deb1[i]==0.
  - fcount resets to 0 whenever that condition is false.
  - At fcount==FAULT_CYCLES-1 with the condition true: fault[i]<=1, fcount saturates.
  - fault is sticky until reset.
- Outputs (registered, updated every edge):
  - sensor_1th[i] = call latch.
  - sensor_5th[i] = deb5[i] & deb1[i] & ~fault[i].
  - sensor_fault[i] = fault[i].
  - sensor_1th is NOT masked by fault.
- Latency: a clean raw step first sampled at edge E appears on deb at edge E+1+DEBOUNCE_CYCLES and on sensor_1th/sensor_5th at edge E+2+DEBOUNCE_CYCLES.
- Call clear latency: deb1 low and green both true at edge G gives sensor_1th low after edge G+1.
- Lanes are fully independent; simultaneous events on several lanes are processed in parallel with no priority.
- Illegal light code 11: treated as not green.

Decomposition:
- Shared package tlc_pkg:
  - Light encoding constants LIGHT_RED=2'b00, LIGHT_YELLOW=2'b01, LIGHT_GREEN=2'b10.
  - Lane index constants LANE_N=0, LANE_E=1, LANE_S=2, LANE_W=3.
  - Both are used by this block and the controller.
- One sub-module, debounce_bit (2-flop sync + debounce counter, parameter DEBOUNCE_CYCLES), instantiated 8 times.
- Call latch and fault logic stay inline in sensor_conditioner.

Test Plan:
1. DEBOUNCE_CYCLES=4: raw_1th[0] held high from edge 10 -> sensor_1th=0001 exactly from edge 16; sensor_5th stays 0000.
2. raw_1th[2] high for 3 cycles only, then low -> sensor_1th never asserts; then 1-cycle glitch on a debounced-high bit -> no drop.
3. Call latched on lane 1; raw_1th[1] drops; Light_east held 01 for 10 cycles, then 10 -> sensor_1th[1] stays 1 through yellow, clears one edge after the first green edge with deb1 low.
4. raw_1th[3] and raw_5th[3] high together -> sensor_5th[3]=1 at edge E+6; drop raw_1th[3] only -> sensor_5th[3]=0 when deb1 falls.
5. FAULT_CYCLES=8: raw_5th[0]=1 with raw_1th[0]=0 held -> sensor_fault=0001 after 8 cycles of debounced condition; later raw_1th[0]=1 -> sensor_5th[0] stays 0, sensor_1th[0]=1; fault persists until rst low.
6. All lanes active with faults set, drive rst=0 for one edge -> all outputs 0000 after that edge; with rst=1 again, outputs re-assert only after full debounce latency.

Source files
------------

// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic light controller and its sensor front end:
// light encodings, lane indices and a green decoder.
package tlc_pkg;

    localparam logic [1:0] LIGHT_RED    = 2'b00;
    localparam logic [1:0] LIGHT_YELLOW = 2'b01;
    localparam logic [1:0] LIGHT_GREEN  = 2'b10;

    localparam int LANE_N = 0;
    localparam int LANE_E = 1;
    localparam int LANE_S = 2;
    localparam int LANE_W = 3;

    // The illegal code 2'b11 falls through to "not green".
    function automatic logic is_green(input logic [1:0] light);
        logic green;
        green = 1'b0;
        case (light)
            LIGHT_RED, LIGHT_YELLOW: green = 1'b0;
            LIGHT_GREEN:             green = 1'b1;
            default:                 green = 1'b0;
        endcase
        return green;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// Two-flop synchroniser followed by a counter debounce: the clean value only
// flips after DEBOUNCE_CYCLES consecutive synchronised disagreements.
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic deb
);

    localparam logic [7:0] COUNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

    logic       meta;
    logic       s;
    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta  <= 1'b0;
            s     <= 1'b0;
            deb   <= 1'b0;
            count <= '0;
        end else begin
            // NOTE: non-blocking so meta->s is a true two-stage shift.
            meta <= raw;
            s    <= meta;
            if (s == deb) begin
                count <= '0;
            end else if (count == COUNT_MAX) begin
                deb   <= s;
                count <= '0;
            end else begin
                count <= count + 8'd1;
            end
        end
    end

endmodule

// File: rtl/sensor_conditioner.sv
// Conditions raw loop detectors into latched call requests, qualified long-queue
// flags and sticky detector-fault flags for the traffic light controller.
module sensor_conditioner
    import tlc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FAULT_CYCLES    = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] loop_1th_raw,
    input  logic [3:0] loop_5th_raw,
    input  logic [1:0] Light_north,
    input  logic [1:0] Light_east,
    input  logic [1:0] Light_south,
    input  logic [1:0] Light_west,
    output logic [3:0] sensor_1th,
    output logic [3:0] sensor_5th,
    output logic [3:0] sensor_fault
);

    localparam logic [15:0] FAULT_MAX = 16'(FAULT_CYCLES - 1);

    logic [3:0]  deb_1th;
    logic [3:0]  deb_5th;
    logic [1:0]  light [4];
    logic [15:0] fcount [4];

    assign light[LANE_N] = Light_north;
    assign light[LANE_E] = Light_east;
    assign light[LANE_S] = Light_south;
    assign light[LANE_W] = Light_west;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_1th (
            .clk (clk),
            .rst (rst),
            .raw (loop_1th_raw[i]),
            .deb (deb_1th[i])
        );
        debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_5th (
            .clk (clk),
            .rst (rst),
            .raw (loop_5th_raw[i]),
            .deb (deb_5th[i])
        );
    end

    // sensor_1th and sensor_fault are the call latches and fault flags themselves.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sensor_1th   <= '0;
            sensor_5th   <= '0;
            sensor_fault <= '0;
            for (int i = 0; i < 4; i++) fcount[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (deb_1th[i]) begin
                    sensor_1th[i] <= 1'b1;
                end else if (is_green(light[i])) begin
                    sensor_1th[i] <= 1'b0;
                end

                sensor_5th[i] <= deb_5th[i] & deb_1th[i] & ~sensor_fault[i];

                // A queue loop active with an empty stop-line loop means a dead 1th detector.
                if (deb_5th[i] && !deb_1th[i]) begin
                    if (fcount[i] == FAULT_MAX) begin
                        sensor_fault[i] <= 1'b1;
                    end else begin
                        fcount[i] <= fcount[i] + 16'd1;
                    end
                end else begin
                    fcount[i] <= '0;
                end
            end
        end
    end

endmodule
